device_event_serializer: RTL and testbench

//  Upstream stage of the active-device counter. Watches N_DEV per-device status lines.
//  - Turns each status edge into a one-cycle change/on_off event (rise=on, fall=off).
//  - Edges from several devices in the same cycle are parked and emitted one per cycle.
//  - The counter downstream never misses or merges an event.

---
 rtl/device_event_serializer_if.sv | 36 +++
 rtl/device_event_serializer.sv | 132 +++++++++++++
 tb/tb_device_event_serializer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/device_event_serializer_if.sv
// Status/event bundle between the device status lines and the active-device counter.
// SERIALIZER_STATS_EN adds the event and cancel totals to the bundle.
interface device_event_serializer_if #(
    parameter int N_DEV = 4,
    parameter int ID_W  = 5
);
    logic [N_DEV-1:0] dev_status;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic             pend_any;
`ifdef SERIALIZER_STATS_EN
    logic [15:0]      evt_total;
    logic [15:0]      cancel_total;

    modport master (
        output dev_status,
        input  change, on_off, dev_id, pend_any,
        input  evt_total, cancel_total
    );
    modport slave (
        input  dev_status,
        output change, on_off, dev_id, pend_any,
        output evt_total, cancel_total
    );
`else
    modport master (
        output dev_status,
        input  change, on_off, dev_id, pend_any
    );
    modport slave (
        input  dev_status,
        output change, on_off, dev_id, pend_any
    );
`endif
endinterface

// File: rtl/device_event_serializer.sv
// Serialises per-device status edges into one on/off event per cycle (round-robin).
// SERIALIZER_STATS_EN adds saturating evt_total / cancel_total counters.
module device_event_serializer #(
    parameter int N_DEV = 4,
    parameter int ID_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    device_event_serializer_if.slave  bus
);
    logic [N_DEV-1:0]   r_dev_q;
    logic [N_DEV-1:0]   r_pend;
    logic [N_DEV-1:0]   r_pdir;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_dev_id;
    logic               r_change;
    logic               r_on_off;
    logic               r_pend_any;

    logic [N_DEV-1:0]   w_edge;
    logic [2*N_DEV-1:0] w_dbl;
    logic [N_DEV-1:0]   w_rot;
    logic               w_gnt_vld;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W:0]      w_sum;
    logic [N_DEV-1:0]   w_gnt_oh;
    logic [N_DEV-1:0]   w_pend_nxt;
    logic [N_DEV-1:0]   w_pdir_nxt;
    logic [N_DEV-1:0]   w_cancel;
    logic [ID_W-1:0]    w_rr_nxt;

    assign w_edge = bus.dev_status ^ r_dev_q;

    // Rotate pending so bit 0 is rr_ptr; first set bit wins.
    always_comb begin
        w_dbl     = {r_pend, r_pend} >> r_rr_ptr;
        w_rot     = w_dbl[N_DEV-1:0];
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int j = 0; j < N_DEV; j++) begin
            if (!w_gnt_vld && w_rot[j]) begin
                w_gnt_vld = 1'b1;
                w_sum     = {1'b0, r_rr_ptr} + (ID_W+1)'(j);
                if (w_sum >= (ID_W+1)'(N_DEV))
                    w_sum = w_sum - (ID_W+1)'(N_DEV);
                w_gnt_idx = w_sum[ID_W-1:0];
            end
        end
        w_gnt_oh = w_gnt_vld ? (N_DEV'(1) << w_gnt_idx) : '0;
        w_rr_nxt = (w_gnt_idx == ID_W'(N_DEV-1)) ? '0 : w_gnt_idx + 1'b1;
    end

    always_comb begin
        w_pend_nxt = r_pend;
        w_pdir_nxt = r_pdir;
        w_cancel   = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (!r_pend[i]) begin
                if (w_edge[i]) begin
                    w_pend_nxt[i] = 1'b1;
                    w_pdir_nxt[i] = bus.dev_status[i];
                end
            end else if (w_gnt_oh[i]) begin
                w_pend_nxt[i] = w_edge[i];
                if (w_edge[i])
                    w_pdir_nxt[i] = bus.dev_status[i];
            end else if (w_edge[i]) begin
                // Opposite edge while still parked: net change is zero.
                w_pend_nxt[i] = 1'b0;
                w_cancel[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dev_q    <= '0;
            r_pend     <= '0;
            r_pdir     <= '0;
            r_rr_ptr   <= '0;
            r_change   <= 1'b0;
            r_on_off   <= 1'b0;
            r_dev_id   <= '0;
            r_pend_any <= 1'b0;
        end else begin
            r_dev_q    <= bus.dev_status;
            r_pend     <= w_pend_nxt;
            r_pdir     <= w_pdir_nxt;
            r_pend_any <= |w_pend_nxt;
            r_change   <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_on_off <= |(r_pdir & w_gnt_oh);
                r_dev_id <= w_gnt_idx;
                r_rr_ptr <= w_rr_nxt;
            end
        end
    end

    assign bus.change   = r_change;
    assign bus.on_off   = r_on_off;
    assign bus.dev_id   = r_dev_id;
    assign bus.pend_any = r_pend_any;

`ifdef SERIALIZER_STATS_EN
    logic [15:0] r_evt_total;
    logic [15:0] r_cancel_total;
    logic [5:0]  w_ncancel;
    logic [16:0] w_csum;

    always_comb begin
        w_ncancel = '0;
        for (int i = 0; i < N_DEV; i++)
            w_ncancel = w_ncancel + 6'(w_cancel[i]);
        w_csum = {1'b0, r_cancel_total} + 17'(w_ncancel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_total    <= '0;
            r_cancel_total <= '0;
        end else begin
            if (w_gnt_vld && r_evt_total != 16'hFFFF)
                r_evt_total <= r_evt_total + 16'd1;
            r_cancel_total <= w_csum[16] ? 16'hFFFF : w_csum[15:0];
        end
    end

    assign bus.evt_total    = r_evt_total;
    assign bus.cancel_total = r_cancel_total;
`endif
endmodule

// File: tb/tb_device_event_serializer.sv
// Directed bench for device_event_serializer (N_DEV=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_device_event_serializer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    device_event_serializer_if #(.N_DEV(4), .ID_W(5)) bus ();

    device_event_serializer #(.N_DEV(4), .ID_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.dev_status = 4'b0000;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_evt(input string tag, input logic on,
                           input logic [4:0] id);
        chk({tag, ".chg"}, 32'(bus.change), 32'd1);
        chk({tag, ".on"},  32'(bus.on_off), 32'(on));
        chk({tag, ".id"},  32'(bus.dev_id), 32'(id));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.dev_status = 4'b0000;

        // 1: reset values, then idle
        tick();
        chk("rst.chg",  32'(bus.change),   32'd0);
        chk("rst.pend", 32'(bus.pend_any), 32'd0);
        chk("rst.id",   32'(bus.dev_id),   32'd0);
        chk("rst.on",   32'(bus.on_off),   32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle.chg", 32'(bus.change), 32'd0);
        end
        chk("idle.pend", 32'(bus.pend_any), 32'd0);

        // 2: single rise on device 2
        bus.dev_status = 4'b0100;
        tick();
        chk("t2.k.chg",  32'(bus.change),   32'd0);
        chk("t2.k.pend", 32'(bus.pend_any), 32'd1);
        tick();
        chk_evt("t2.ev", 1'b1, 5'd2);
        chk("t2.pend", 32'(bus.pend_any), 32'd0);
        tick();
        chk("t2.after", 32'(bus.change), 32'd0);

        // 3: all four rise together
        do_reset();
        bus.dev_status = 4'b1111;
        tick();
        chk("t3.k.chg", 32'(bus.change), 32'd0);
        for (int d = 0; d < 4; d++) begin
            tick();
            chk_evt($sformatf("t3.ev%0d", d), 1'b1, 5'(d));
        end
        chk("t3.pend", 32'(bus.pend_any), 32'd0);
        tick();
        chk("t3.after", 32'(bus.change), 32'd0);

        // 4: 0000->1111->0011, devices 2 and 3 cancel
        do_reset();
        bus.dev_status = 4'b1111;
        tick();
        bus.dev_status = 4'b0011;
        tick();
        chk_evt("t4.ev0", 1'b1, 5'd0);
        tick();
        chk_evt("t4.ev1", 1'b1, 5'd1);
        chk("t4.pend", 32'(bus.pend_any), 32'd0);
        tick();
        chk("t4.after", 32'(bus.change), 32'd0);
`ifdef SERIALIZER_STATS_EN
        chk("t4.evt",    32'(bus.evt_total),    32'd2);
        chk("t4.cancel", 32'(bus.cancel_total), 32'd2);
`endif

        // 5: device 1 falls on the edge its "on" is granted
        do_reset();
        bus.dev_status = 4'b0010;
        tick();
        chk("t5.k.chg", 32'(bus.change), 32'd0);
        bus.dev_status = 4'b0000;
        tick();
        chk_evt("t5.on", 1'b1, 5'd1);
        chk("t5.pend1", 32'(bus.pend_any), 32'd1);
        tick();
        chk_evt("t5.off", 1'b0, 5'd1);
        chk("t5.pend0", 32'(bus.pend_any), 32'd0);
        tick();
        chk("t5.after", 32'(bus.change), 32'd0);

        // 6: reset with three events parked, release with 1010
        do_reset();
        bus.dev_status = 4'b0111;
        tick();
        chk("t6.parked", 32'(bus.pend_any), 32'd1);
        rst_n = 1'b0;
        bus.dev_status = 4'b1010;
        #1;
        chk("t6.async.chg",  32'(bus.change),   32'd0);
        chk("t6.async.pend", 32'(bus.pend_any), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6.k.chg", 32'(bus.change), 32'd0);
        tick();
        chk_evt("t6.ev1", 1'b1, 5'd1);
        tick();
        chk_evt("t6.ev3", 1'b1, 5'd3);
        chk("t6.pend", 32'(bus.pend_any), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t6.stale", 32'(bus.change), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
